fsic_io_serdes_rx_deser: RTL

Multi-lane, single-clock receive deserializer for the FSIC IO SerDes link, successor to the fixed 4:1 single-lane RX path. It samples pNUM_LANE serial lanes on ioclk and aligns word boundaries by hunting for a training word on lane 0. It assembles pCLK_RATIO-bit words per lane and delivers them through a first-word-fall-through FIFO with a valid/ready handshake, with lock and overflow status. It sits between the IO pad sampling logic and the core-side AXIS receive logic.

---
 rtl/fsic_io_serdes_rx_deser.sv | 160 ++++++++++++++++
 1 files changed

// File: rtl/fsic_io_serdes_rx_deser.sv
// Multi-lane receive deserializer: lane-0 training-word alignment, per-lane word
// assembly, and a first-word-fall-through output FIFO with lock/overflow status.
module fsic_io_serdes_rx_deser #(
    parameter int unsigned             pNUM_LANE   = 2,
    parameter int unsigned             pCLK_RATIO  = 4,
    parameter logic [pCLK_RATIO-1:0]   pTRAIN_WORD = 4'b0011,
    parameter int unsigned             pLOCK_CNT   = 3,
    parameter int unsigned             pFIFO_DEPTH = 4
) (
    input  logic                              ioclk,
    input  logic                              axis_rst,
    input  logic                              rxen,
    input  logic [pNUM_LANE-1:0]              serial_in,
    output logic [pNUM_LANE*pCLK_RATIO-1:0]   rx_word,
    output logic                              rx_word_valid,
    input  logic                              rx_word_ready,
    output logic                              rx_locked,
    output logic                              rx_overflow
);

    localparam int unsigned PH_W   = $clog2(pCLK_RATIO);
    localparam int unsigned CNT_W  = $clog2(pLOCK_CNT + 1);
    localparam int unsigned AW     = $clog2(pFIFO_DEPTH);
    localparam int unsigned WORD_W = pNUM_LANE * pCLK_RATIO;

    typedef enum logic [1:0] {HUNT, VERIFY, LOCKED} state_t;

    state_t                                 r_state;
    state_t                                 w_state_nxt;
    logic [pNUM_LANE-1:0][pCLK_RATIO-1:0]   r_shreg;
    logic [pNUM_LANE-1:0][pCLK_RATIO-1:0]   w_win;
    logic [PH_W-1:0]                        r_phase;
    logic [CNT_W-1:0]                       r_match_cnt;
    logic [CNT_W-1:0]                       w_cnt_nxt;
    logic                                   w_phase_rst;
    logic                                   w_boundary;
    logic                                   w_match;
    logic                                   w_push;
    logic                                   r_locked;
    logic                                   r_overflow;

    logic [WORD_W-1:0]                      r_mem [pFIFO_DEPTH];
    logic [AW:0]                            r_wptr;
    logic [AW:0]                            r_rptr;
    logic                                   w_empty;
    logic                                   w_full;
    logic                                   w_pop;
    logic                                   w_push_ok;

    // Window is the shift register's next value: newest bit enters at the MSB.
    always_comb begin
        for (int unsigned k = 0; k < pNUM_LANE; k++) begin
            w_win[k] = {serial_in[k], r_shreg[k][pCLK_RATIO-1:1]};
        end
    end

    assign w_boundary = (r_phase == PH_W'(pCLK_RATIO - 1));
    assign w_match    = (w_win[0] == pTRAIN_WORD);

    // Alignment FSM: state register.
    always_ff @(posedge ioclk or posedge axis_rst) begin
        if (axis_rst) begin
            r_state <= HUNT;
        end else if (!rxen) begin
            r_state <= HUNT;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Alignment FSM: next state, match counting and push decision.
    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_match_cnt;
        w_phase_rst = 1'b0;
        w_push      = 1'b0;
        case (r_state)
            HUNT: begin
                if (w_match) begin
                    w_phase_rst = 1'b1;
                    w_cnt_nxt   = CNT_W'(1);
                    w_state_nxt = (pLOCK_CNT == 1) ? LOCKED : VERIFY;
                end
            end
            VERIFY: begin
                if (w_boundary) begin
                    if (w_match) begin
                        w_cnt_nxt = r_match_cnt + CNT_W'(1);
                        if ((r_match_cnt + CNT_W'(1)) == CNT_W'(pLOCK_CNT)) begin
                            w_state_nxt = LOCKED;
                        end
                    end else begin
                        w_cnt_nxt   = '0;
                        w_state_nxt = HUNT;
                    end
                end
            end
            LOCKED: begin
                w_push = w_boundary;
            end
            default: begin
                w_state_nxt = HUNT;
            end
        endcase
    end

    assign w_empty   = (r_wptr == r_rptr);
    assign w_full    = (r_wptr[AW] != r_rptr[AW]) && (r_wptr[AW-1:0] == r_rptr[AW-1:0]);
    assign w_pop     = !w_empty && rx_word_ready;
    assign w_push_ok = w_push && (!w_full || w_pop);

    // Datapath, phase, status and FIFO pointers; rxen low flushes everything but storage.
    always_ff @(posedge ioclk or posedge axis_rst) begin
        if (axis_rst) begin
            r_shreg     <= '0;
            r_phase     <= '0;
            r_match_cnt <= '0;
            r_locked    <= 1'b0;
            r_overflow  <= 1'b0;
            r_wptr      <= '0;
            r_rptr      <= '0;
            for (int i = 0; i < pFIFO_DEPTH; i++) begin
                r_mem[i] <= '0;
            end
        end else if (!rxen) begin
            r_shreg     <= '0;
            r_phase     <= '0;
            r_match_cnt <= '0;
            r_locked    <= 1'b0;
            r_overflow  <= 1'b0;
            r_wptr      <= '0;
            r_rptr      <= '0;
        end else begin
            r_shreg     <= w_win;
            r_match_cnt <= w_cnt_nxt;
            r_locked    <= (w_state_nxt == LOCKED);
            if (w_phase_rst || w_boundary) begin
                r_phase <= '0;
            end else begin
                r_phase <= r_phase + PH_W'(1);
            end
            if (w_push_ok) begin
                r_mem[r_wptr[AW-1:0]] <= w_win;
                r_wptr                <= r_wptr + (AW+1)'(1);
            end
            if (w_pop) begin
                r_rptr <= r_rptr + (AW+1)'(1);
            end
            if (w_push && !w_push_ok) begin
                r_overflow <= 1'b1;
            end
        end
    end

    assign rx_word       = r_mem[r_rptr[AW-1:0]];
    assign rx_word_valid = !w_empty;
    assign rx_locked     = r_locked;
    assign rx_overflow   = r_overflow;

endmodule
